main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Main-memory side of the cache-controller/memory handshake.
- Accepts line-granular read (allocate) and write (writeback) requests, models programmable access latency and moves a full cache line as word beats.
- Signals completion with a one-cycle Main_mem_ack pulse.
- Used as the memory endpoint in cache subsystem simulation and as the basis for the FPGA memory bridge.

Parameters:
- ADDR_WIDTH, 8, line-index width; memory holds 2**ADDR_WIDTH lines, so no address is out of range.
- WORD_WIDTH, 32, bits per beat.
- WORDS_PER_LINE, 4, beats per line; power of two, at least 2.
- READ_LATENCY, 4, RD_WAIT cycles before the first read beat; at least 1.
- WRITE_LATENCY, 2, WR_WAIT cycles after the last write beat; at least 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read_req  input  1  line read request; sampled only in IDLE.
- mem_write_req  input  1  line write request; sampled only in IDLE.
- mem_addr  input  ADDR_WIDTH  line index; captured when a request is accepted.
- wdata  input  WORD_WIDTH  write beat data.
- wdata_valid  input  1  write beat valid; honoured only in WR_DATA.
- rdata  output  WORD_WIDTH  read beat data.
- rdata_valid  output  1  read beat valid.
- Main_mem_ack  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- rd_count  output  16  completed reads; wraps.
- wr_count  output  16  completed writes; wraps.
- state  output  3  current state, for debug.

Behaviour:
- State encoding: IDLE=0, WR_DATA=1, WR_WAIT=2, RD_WAIT=3, RD_DATA=4, ACK=5. Other codes go to IDLE.
- Reset: state=IDLE. rdata=0, rdata_valid=0, Main_mem_ack=0, busy=0, rd_count=0, wr_count=0. Latency counter and beat index are cleared.
- Reset mid-transaction: aborts to IDLE, no ack is issued, counters clear. The memory array is never reset; beats already written stay written.
- IDLE, request acceptance:
  - mem_write_req=1: capture mem_addr, beat=0, next state WR_DATA.
  - Else mem_read_req=1: capture mem_addr, latency counter=READ_LATENCY-1, next state RD_WAIT.
  - Both high: write wins, and the read is ignored, not queued.
- Requests and address changes in any non-IDLE state are ignored.
- WR_DATA:
  - Each cycle with wdata_valid=1 writes mem[addr][beat]=wdata and increments beat.
  - wdata_valid=0 stalls indefinitely; there is no timeout.
  - On the cycle the beat WORDS_PER_LINE-1 is written: latency counter=WRITE_LATENCY-1, next state WR_WAIT.
- WR_WAIT: decrement the counter each cycle; when it reads 0, next state ACK.
- RD_WAIT: same countdown, lasting READ_LATENCY cycles; then beat=0, next state RD_DATA.
- RD_DATA:
  - Exactly WORDS_PER_LINE consecutive cycles with rdata_valid=1 and rdata=mem[addr][beat]. There is no backpressure.
  - After the last beat, next state ACK.
  - rdata=0 whenever rdata_valid=0.
- ACK: Main_mem_ack=1 for exactly one cycle. Increment rd_count or wr_count by 1, with 16-bit wrap (0xFFFF→0x0000). Next state IDLE.
- Read timing, with the request sampled at edge 0:
  - RD_WAIT in cycles 1..L.
  - Beats in cycles L+1..L+N.
  - Ack in cycle L+N+1.
  - The next request can be sampled at edge L+N+2.
- Write timing: ack comes WRITE_LATENCY+1 cycles after the cycle of the last accepted beat.
- Read-after-write to the same line returns the newly written data.
- Beat index and word select wrap via a log2(WORDS_PER_LINE)-bit counter.

Test Plan:
- Reset, then idle for 10 cycles → all outputs 0, state=0, busy=0.
- Write line 0x12 with beats A0..A3, wdata_valid continuous → ack 3 cycles after the beat-A3 cycle, wr_count=1. Then read 0x12 → 4 cycles of RD_WAIT, beats A0,A1,A2,A3 in order with rdata_valid=1, ack on the next cycle, rd_count=1.
- Write with wdata_valid gaps (pattern 1,0,0,1,1,0,1) → exactly 4 beats stored; ack timing is measured from the 4th valid beat.
- mem_read_req and mem_write_req both high in IDLE → WR_DATA is entered; the read is dropped and rd_count is unchanged. A request pulsed while busy produces no response.
- Assert reset in RD_DATA after beat 1 → no ack, state=0, counters=0. A later read of the same line returns the original data.
- Preload wr_count to 0xFFFF via 65535 writes (or a force) → after the next write, wr_count=0x0000.

Source files
------------

// File: rtl/main_mem_responder.sv
// ============================================================================
// Module   : main_mem_responder
// Brief    : Line-granular main-memory endpoint with programmable latency,
//            word-beat transfers and a one-cycle completion ack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module main_mem_responder #(
    parameter int ADDR_WIDTH     = 8,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_req,
    input  logic                  mem_write_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  Main_mem_ack,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic [2:0]            state
);

    localparam int c_BEAT_W  = $clog2(WORDS_PER_LINE);
    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_LAT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam int c_DEPTH   = (2 ** ADDR_WIDTH) * WORDS_PER_LINE;

    localparam logic [c_LAT_W-1:0]  c_RD_LOAD   = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [c_LAT_W-1:0]  c_WR_LOAD   = c_LAT_W'(WRITE_LATENCY - 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(WORDS_PER_LINE - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_DATA = 3'd1;
    localparam logic [2:0] c_WR_WAIT = 3'd2;
    localparam logic [2:0] c_RD_WAIT = 3'd3;
    localparam logic [2:0] c_RD_DATA = 3'd4;
    localparam logic [2:0] c_ACK     = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_LAT_W-1:0]    r_lat;
    logic                  r_is_write;
    logic [15:0]           r_rd_count;
    logic [15:0]           r_wr_count;
    logic                  w_mem_we;

    // Flat storage indexed by {line, beat}; deliberately never reset.
    logic [WORD_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (mem_write_req)     w_next_state = c_WR_DATA;
                else if (mem_read_req) w_next_state = c_RD_WAIT;
                else                   w_next_state = c_IDLE;
            end
            c_WR_DATA: w_next_state = (wdata_valid && (r_beat == c_LAST_BEAT)) ? c_WR_WAIT : c_WR_DATA;
            c_WR_WAIT: w_next_state = (r_lat == '0) ? c_ACK : c_WR_WAIT;
            c_RD_WAIT: w_next_state = (r_lat == '0) ? c_RD_DATA : c_RD_WAIT;
            c_RD_DATA: w_next_state = (r_beat == c_LAST_BEAT) ? c_ACK : c_RD_DATA;
            c_ACK:     w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_is_write <= 1'b0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (mem_write_req) begin
                        r_addr     <= mem_addr;
                        r_beat     <= '0;
                        r_is_write <= 1'b1;
                    end else if (mem_read_req) begin
                        r_addr     <= mem_addr;
                        r_lat      <= c_RD_LOAD;
                        r_is_write <= 1'b0;
                    end
                end
                c_WR_DATA: begin
                    if (wdata_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == c_LAST_BEAT) r_lat <= c_WR_LOAD;
                    end
                end
                c_WR_WAIT: begin
                    if (r_lat != '0) r_lat <= r_lat - 1'b1;
                end
                c_RD_WAIT: begin
                    if (r_lat != '0) r_lat  <= r_lat - 1'b1;
                    else             r_beat <= '0;
                end
                c_RD_DATA: r_beat <= r_beat + 1'b1;
                c_ACK: begin
                    if (r_is_write) r_wr_count <= r_wr_count + 16'd1;
                    else            r_rd_count <= r_rd_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Reset blocks the store so an aborted write cannot land a stray beat.
    assign w_mem_we = !reset && (r_state == c_WR_DATA) && wdata_valid;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[{r_addr, r_beat}] <= wdata;
    end

    assign rdata_valid  = (r_state == c_RD_DATA);
    assign rdata        = rdata_valid ? r_mem[{r_addr, r_beat}] : '0;
    assign Main_mem_ack = (r_state == c_ACK);
    assign busy         = (r_state != c_IDLE);
    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_responder.sv
// ============================================================================
// Module   : tb_main_mem_responder
// Brief    : Directed self-checking bench for main_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_main_mem_responder;

    localparam int c_RL = 4;
    localparam int c_WL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [7:0]  mem_addr;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        Main_mem_ack;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    main_mem_responder #(
        .ADDR_WIDTH     (8),
        .WORD_WIDTH     (32),
        .WORDS_PER_LINE (4),
        .READ_LATENCY   (c_RL),
        .WRITE_LATENCY  (c_WL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_addr      (mem_addr),
        .wdata         (wdata),
        .wdata_valid   (wdata_valid),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .Main_mem_ack  (Main_mem_ack),
        .busy          (busy),
        .rd_count      (rd_count),
        .wr_count      (wr_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack"}, 32'(Main_mem_ack), 32'd0);
        check({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // pat[i] gives wdata_valid for the i-th WR_DATA cycle; past plen valid is held high.
    task automatic write_line(input string tag, input logic [7:0] addr, input logic [31:0] base,
                              input logic [15:0] pat, input int plen, input logic also_read,
                              input logic [15:0] exp_wr);
        int k;
        int i;
        int n;
        logic v;
        mem_write_req = 1'b1;
        mem_read_req  = also_read;
        mem_addr      = addr;
        step();
        mem_write_req = 1'b0;
        mem_read_req  = 1'b0;
        mem_addr      = 8'hFF;
        check({tag, "_enter"}, 32'(state), 32'd1);
        k = 0;
        i = 0;
        while (k < 4 && i < 64) begin
            v           = (i < plen) ? pat[i] : 1'b1;
            wdata_valid = v;
            wdata       = v ? base + 32'(k) : 32'hDEAD_BEEF;
            step();
            if (v) k++;
            i++;
        end
        wdata_valid = 1'b0;
        wdata       = 32'd0;
        n = 0;
        while (!Main_mem_ack && n < 16) begin
            step();
            n++;
        end
        check({tag, "_acklat"}, 32'(n + 1), 32'(c_WL + 1));
        step();
        check({tag, "_ackpulse"}, 32'(Main_mem_ack), 32'd0);
        check({tag, "_wrcnt"}, 32'(wr_count), 32'(exp_wr));
    endtask

    // With poke set, a write request to another line is pulsed during RD_WAIT.
    task automatic read_line(input string tag, input logic [7:0] addr, input logic [31:0] base,
                             input logic poke, input logic [15:0] exp_rd);
        int n;
        mem_read_req = 1'b1;
        mem_addr     = addr;
        step();
        mem_read_req = 1'b0;
        if (poke) begin
            mem_write_req = 1'b1;
            mem_addr      = 8'h55;
        end
        n = 0;
        while (!rdata_valid && n < 32) begin
            step();
            mem_write_req = 1'b0;
            n++;
        end
        check({tag, "_rdlat"}, 32'(n), 32'(c_RL));
        for (int b = 0; b < 4; b++) begin
            check({tag, "_rvalid"}, 32'(rdata_valid), 32'd1);
            check({tag, "_rdata"}, rdata, base + 32'(b));
            step();
        end
        check({tag, "_ack"}, 32'(Main_mem_ack), 32'd1);
        check({tag, "_acks"}, 32'(state), 32'd5);
        step();
        check_idle({tag, "_post"});
        check({tag, "_rdcnt"}, 32'(rd_count), 32'(exp_rd));
    endtask

    initial begin
        reset         = 1'b1;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        mem_addr      = 8'd0;
        wdata         = 32'd0;
        wdata_valid   = 1'b0;
        step();
        step();
        reset = 1'b0;

        for (int c = 0; c < 10; c++) step();
        check_idle("reset");
        check("reset_rdcnt", 32'(rd_count), 32'd0);
        check("reset_wrcnt", 32'(wr_count), 32'd0);

        // Continuous write then readback.
        write_line("wrA", 8'h12, 32'hA000_00A0, 16'h0, 0, 1'b0, 16'd1);
        read_line("rdA", 8'h12, 32'hA000_00A0, 1'b0, 16'd1);

        // Gapped write: valid pattern 1,0,0,1,1,0,1 (LSB first).
        write_line("wrB", 8'h34, 32'hB000_00B0, 16'b1011001, 7, 1'b0, 16'd2);
        read_line("rdB", 8'h34, 32'hB000_00B0, 1'b0, 16'd2);

        // Simultaneous requests: write wins, read dropped.
        write_line("wrC", 8'h56, 32'hC000_00C0, 16'h0, 0, 1'b1, 16'd3);
        check("both_rdcnt", 32'(rd_count), 32'd2);
        for (int c = 0; c < 3; c++) step();
        check("both_noread", 32'(state), 32'd0);

        // Write request pulsed while busy is ignored.
        read_line("rdC", 8'h56, 32'hC000_00C0, 1'b1, 16'd3);
        for (int c = 0; c < 3; c++) step();
        check("poke_state", 32'(state), 32'd0);
        check("poke_wrcnt", 32'(wr_count), 32'd3);
        read_line("rd55", 8'h12, 32'hA000_00A0, 1'b0, 16'd4);

        // Reset in RD_DATA after the second beat.
        mem_read_req = 1'b1;
        mem_addr     = 8'h12;
        step();
        mem_read_req = 1'b0;
        for (int c = 0; c < c_RL; c++) step();
        check("abort_beat0", rdata, 32'hA000_00A0);
        step();
        check("abort_beat1", rdata, 32'hA000_00A1);
        step();
        reset = 1'b1;
        step();
        check("abort_noack", 32'(Main_mem_ack), 32'd0);
        reset = 1'b0;
        check_idle("abort");
        check("abort_rdcnt", 32'(rd_count), 32'd0);
        check("abort_wrcnt", 32'(wr_count), 32'd0);
        for (int c = 0; c < 4; c++) step();
        check("abort_stillidle", 32'(Main_mem_ack), 32'd0);
        read_line("rdA2", 8'h12, 32'hA000_00A0, 1'b0, 16'd1);

        // Write-counter wrap.
        force dut.r_wr_count = 16'hFFFF;
        #1;
        release dut.r_wr_count;
        step();
        check("wrap_pre", 32'(wr_count), 32'h0000_FFFF);
        write_line("wrD", 8'h78, 32'hD000_00D0, 16'h0, 0, 1'b0, 16'h0000);
        read_line("rdD", 8'h78, 32'hD000_00D0, 1'b0, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
